// File: rtl/reg4_arb_pkg.sv
// Shared types and constants for the 4-bit register write arbiter.
// Holds the sequencer state encoding and a modulo helper used for pointer math.
package reg4_arb_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    // (a + b) mod n for small non-negative operands (a < n, b < n).
    function automatic int mod_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/reg4_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping modulo N_REQ.
module rr_picker
    import reg4_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;

    // Rotate so that bit 0 of req_rot is the requester the pointer names.
    assign req_dbl = {i_req, i_req};
    assign req_rot = req_dbl[i_ptr +: N_REQ];

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Descending scan: the lowest rotated offset is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                o_idx = PTR_W'(mod_add(int'(i_ptr), i, N_REQ));
            end
        end
    end

endmodule

// File: rtl/reg4_write_arbiter.sv
// Shares one external 4-bit enable register between N_REQ writers using a
// round-robin pick and an IDLE -> GRANT -> WRITE sequencer.
module reg4_write_arbiter
    import reg4_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_en,
    output logic [DATA_W-1:0]       o_d,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_write_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [PTR_W-1:0]   win_q,   win_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  pick_data;
    logic [N_REQ-1:0]   win_onehot;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) pick_data = i_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    data_d  = pick_data;
                    state_d = GRANT;
                end
            end
            GRANT: state_d = WRITE;
            WRITE: begin
                // Pointer and count only move once a write has fully committed.
                ptr_d   = PTR_W'(mod_add(int'(win_q), 1, N_REQ));
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only state and hold registers, so reset clears them at once.
    always_comb begin
        win_onehot    = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
        o_grant       = (state_q != IDLE)  ? win_onehot : '0;
        o_ack         = (state_q == WRITE) ? win_onehot : '0;
        o_en          = (state_q == WRITE);
        o_d           = data_q;
        o_busy        = (state_q != IDLE);
        o_write_count = cnt_q;
    end

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Directed bench for reg4_write_arbiter with a write scoreboard and a
// behavioural model of the downstream 4-bit enable register.
module tb_reg4_write_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 4;
    localparam int CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*DW-1:0]   data;
    logic [N_REQ-1:0]      o_grant, o_ack;
    logic                  o_en, o_busy;
    logic [DW-1:0]         o_d;
    logic [CNT_W-1:0]      o_write_count;

    typedef struct {
        int         idx;
        logic [3:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    int         en_pulses = 0;
    int         ack_seen [N_REQ];
    logic [3:0] reg_q = '0;
    int         base;

    always #5 clk = ~clk;

    reg4_write_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req),
        .i_data        (data),
        .o_grant       (o_grant),
        .o_ack         (o_ack),
        .o_en          (o_en),
        .o_d           (o_d),
        .o_busy        (o_busy),
        .o_write_count (o_write_count)
    );

    // Stand-in for the external register_en_4.
    always @(posedge clk) if (o_en) reg_q <= o_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] d);
        exp_t x;
        x.idx  = idx;
        x.data = d;
        sb.push_back(x);
    endtask

    // Scoreboard: each observed write must match the oldest expected one.
    always @(negedge clk) begin
        check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
        check("ack_onehot0",   32'($onehot0(o_ack)),   32'd1);
        if (o_en) begin
            en_pulses++;
            check("en_has_ack", 32'(o_ack != '0), 32'd1);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_data",  32'(o_d),     32'(e.data));
                check("wr_ack",   32'(o_ack),   32'(4'b0001 << e.idx));
                check("wr_grant", 32'(o_grant), 32'(4'b0001 << e.idx));
            end
            for (int k = 0; k < N_REQ; k++) ack_seen[k] += int'(o_ack[k]);
        end
    end

    initial begin
        for (int k = 0; k < N_REQ; k++) ack_seen[k] = 0;
        rst_n = 1'b0;
        req   = '0;
        data  = '0;

        // 1. reset then idle
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({o_grant, o_ack, o_en, o_d, o_busy, o_write_count}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({o_grant, o_ack, o_en, o_d, o_busy, o_write_count}), 32'd0);
        end

        // 2. single write from requester 2
        req  = 4'b0100;
        data = 16'h0A00;
        push(2, 4'hA);
        @(negedge clk);
        check("t2_grant", 32'(o_grant), 32'h4);
        check("t2_en_in_grant", 32'(o_en), 32'd0);
        check("t2_d_in_grant", 32'(o_d), 32'hA);
        check("t2_busy", 32'(o_busy), 32'd1);
        @(negedge clk);
        check("t2_en", 32'(o_en), 32'd1);
        check("t2_ack", 32'(o_ack), 32'h4);
        req = '0;
        @(negedge clk);
        check("t2_reg_q", 32'(reg_q), 32'hA);
        check("t2_count", 32'(o_write_count), 32'd1);
        check("t2_busy_idle", 32'(o_busy), 32'd0);

        // 3. round-robin with all four requesting, pointer restarted at 0
        rst_n = 1'b0;
        for (int k = 0; k < N_REQ; k++) ack_seen[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req  = 4'b1111;
        data = 16'h4321;
        push(0, 4'h1); push(1, 4'h2); push(2, 4'h3); push(3, 4'h4); push(0, 4'h1);
        repeat (14) @(negedge clk);
        check("t3_ack_in_last", 32'(o_ack), 32'h1);
        req = '0;
        @(negedge clk);
        check("t3_count", 32'(o_write_count), 32'd5);
        check("t3_reg_q", 32'(reg_q), 32'h1);
        check("t3_acks0", 32'(ack_seen[0]), 32'd2);
        check("t3_acks1", 32'(ack_seen[1]), 32'd1);
        check("t3_acks2", 32'(ack_seen[2]), 32'd1);
        check("t3_acks3", 32'(ack_seen[3]), 32'd1);

        // 4. data change and request drop during GRANT do not cancel the write
        req  = 4'b0010;
        data = 16'h0050;
        push(1, 4'h5);
        @(negedge clk);
        check("t4_grant", 32'(o_grant), 32'h2);
        req  = '0;
        data = 16'h00F0;
        @(negedge clk);
        check("t4_d", 32'(o_d), 32'h5);
        @(negedge clk);
        check("t4_reg_q", 32'(reg_q), 32'h5);
        check("t4_count", 32'(o_write_count), 32'd6);

        // 5. reset in the middle of WRITE aborts the write
        req  = 4'b1000;
        data = 16'h7000;
        push(3, 4'h7);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("t5_en_before", 32'(o_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_abort_outputs", 32'({o_grant, o_ack, o_en, o_busy, o_write_count}), 32'd0);
        @(negedge clk);
        check("t5_reg_unchanged", 32'(reg_q), 32'h5);
        rst_n = 1'b1;
        req  = 4'b1001;
        data = 16'h9008;
        push(0, 4'h8);
        @(negedge clk);
        check("t5_ptr_restart", 32'(o_grant), 32'h1);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("t5_count", 32'(o_write_count), 32'd1);
        check("t5_reg_q", 32'(reg_q), 32'h8);

        // 6. counter wrap over 256 back-to-back writes
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = en_pulses;
        req  = 4'b0100;
        data = 16'h0C00;
        for (int i = 0; i < 256; i++) push(2, 4'hC);
        for (int i = 1; i <= 256; i++) begin
            repeat (2) @(negedge clk);
            if (i == 256) req = '0;
            @(negedge clk);
            if (i == 255) check("t6_count_255", 32'(o_write_count), 32'd255);
            if (i == 256) check("t6_count_wrap", 32'(o_write_count), 32'd0);
        end
        check("t6_en_pulses", 32'(en_pulses - base), 32'd256);
        repeat (3) @(negedge clk);
        check("t6_no_extra", 32'(o_busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
